// File: rtl/st_seg_concat_pkg.sv
// Shared definitions for the segment concatenator: FSM state encoding,
// CSR register map and counter widths.
package st_seg_concat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER  = 3'd1,
        ST_ABORT = 3'd2
    } state_e;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_PKT    = 2'd1;
    localparam logic [1:0] CSR_ABORT  = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam int CNT_W      = 32;
    localparam int DROP_W     = 16;
    localparam int DROP_ADD_W = 4;
    localparam int TMO_W      = 32;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value, input logic inc);
        return (inc && (value != '1)) ? value + CNT_W'(1) : value;
    endfunction

    // Several segments can be flushed in the same cycle, so drops add a count.
    function automatic logic [DROP_W-1:0] satAdd(input logic [DROP_W-1:0] value,
                                                 input logic [DROP_ADD_W-1:0] amount);
        logic [DROP_W:0] sum;
        sum = {1'b0, value} + {{(DROP_W + 1 - DROP_ADD_W){1'b0}}, amount};
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/st_seg_concat_if.sv
// Bundles the segment sinks, the merged source and the CSR slave port.
interface st_seg_concat_if #(
    parameter int NUM_SEG = 3,
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
);
    logic [NUM_SEG*DATA_W-1:0]  seg_data;
    logic [NUM_SEG-1:0]         seg_valid;
    logic [NUM_SEG-1:0]         seg_sop;
    logic [NUM_SEG-1:0]         seg_eop;
    logic [NUM_SEG*EMPTY_W-1:0] seg_empty;
    logic [NUM_SEG-1:0]         seg_ready;

    logic [DATA_W-1:0]          to_udp_data;
    logic                       to_udp_valid;
    logic                       to_udp_sop;
    logic                       to_udp_eop;
    logic [EMPTY_W-1:0]         to_udp_empty;
    logic                       to_udp_ready;

    logic [1:0]                 csr_address;
    logic                       csr_read;
    logic                       csr_write;
    logic [31:0]                csr_writedata;
    logic [31:0]                csr_readdata;

    modport slave (
        input  seg_data, seg_valid, seg_sop, seg_eop, seg_empty,
        output seg_ready,
        output to_udp_data, to_udp_valid, to_udp_sop, to_udp_eop, to_udp_empty,
        input  to_udp_ready,
        input  csr_address, csr_read, csr_write, csr_writedata,
        output csr_readdata
    );

    modport master (
        output seg_data, seg_valid, seg_sop, seg_eop, seg_empty,
        input  seg_ready,
        input  to_udp_data, to_udp_valid, to_udp_sop, to_udp_eop, to_udp_empty,
        output to_udp_ready,
        output csr_address, csr_read, csr_write, csr_writedata,
        input  csr_readdata
    );
endinterface

// File: rtl/st_seg_concat_csr.sv
// Control register, saturating packet/abort/drop counters and the
// registered Avalon-MM readback mux.
module st_seg_concat_csr
    import st_seg_concat_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_address,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [31:0]           i_writedata,
    output logic [31:0]           o_readdata,
    input  logic                  i_pktInc,
    input  logic                  i_abortInc,
    input  logic [DROP_ADD_W-1:0] i_dropAdd,
    input  state_e                i_state,
    input  logic [7:0]            i_k,
    output logic                  o_enable
);

    logic              r_enable;
    logic [CNT_W-1:0]  r_pktCnt;
    logic [CNT_W-1:0]  r_abortCnt;
    logic [DROP_W-1:0] r_dropCnt;
    logic [31:0]       r_readdata;

    logic              w_ctrlWr;
    logic              w_clear;
    logic [31:0]       w_rdMux;
    logic              w_unusedWrBits;

    assign w_ctrlWr       = i_write && (i_address == CSR_CTRL);
    assign w_clear        = w_ctrlWr && i_writedata[1];
    assign w_unusedWrBits = ^i_writedata[31:2];

    // The clear bit is a pulse, not storage; it wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= 1'b1;
            r_pktCnt   <= '0;
            r_abortCnt <= '0;
            r_dropCnt  <= '0;
        end else begin
            if (w_ctrlWr) begin
                r_enable <= i_writedata[0];
            end
            if (w_clear) begin
                r_pktCnt   <= '0;
                r_abortCnt <= '0;
                r_dropCnt  <= '0;
            end else begin
                r_pktCnt   <= satInc(r_pktCnt, i_pktInc);
                r_abortCnt <= satInc(r_abortCnt, i_abortInc);
                r_dropCnt  <= satAdd(r_dropCnt, i_dropAdd);
            end
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (i_address)
            CSR_CTRL:   w_rdMux = {31'd0, r_enable};
            CSR_PKT:    w_rdMux = r_pktCnt;
            CSR_ABORT:  w_rdMux = r_abortCnt;
            CSR_STATUS: w_rdMux = {r_dropCnt, 5'd0, i_state, i_k};
            default:    w_rdMux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readdata <= '0;
        end else if (i_read) begin
            r_readdata <= w_rdMux;
        end
    end

    assign o_readdata = r_readdata;
    assign o_enable   = r_enable;

endmodule

// File: rtl/st_seg_concat.sv
// Concatenates NUM_SEG Avalon-ST segment streams into one packet with a
// zero-latency forwarding mux, idle-timeout abort and IDLE-time flushing.
module st_seg_concat
    import st_seg_concat_pkg::*;
#(
    parameter int                NUM_SEG    = 3,
    parameter int                DATA_W     = 32,
    parameter int                EMPTY_W    = 2,
    parameter int                TIMEOUT    = 1024,
    parameter logic [DATA_W-1:0] ABORT_WORD = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          rst_n,
    st_seg_concat_if.slave bus
);

    localparam int               KW        = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [KW-1:0]    LAST_K    = KW'(NUM_SEG - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_e             r_state;
    logic [KW-1:0]      r_k;
    logic [TMO_W-1:0]   r_tmo;

    state_e             w_stateNxt;
    logic [KW-1:0]      w_kNxt;
    logic [TMO_W-1:0]   w_tmoNxt;
    logic               w_pktInc;
    logic               w_abortInc;
    logic [DROP_ADD_W-1:0] w_dropAdd;
    logic               w_enable;
    logic               w_isLast;
    logic [NUM_SEG-1:0] w_segReady;
    logic               w_outValid;
    logic [DATA_W-1:0]  w_outData;
    logic               w_outSop;
    logic               w_outEop;
    logic [EMPTY_W-1:0] w_outEmpty;

    logic [DATA_W-1:0]  w_segWord  [NUM_SEG];
    logic [EMPTY_W-1:0] w_segEmpty [NUM_SEG];

    for (genvar g = 0; g < NUM_SEG; g++) begin : g_unpack
        assign w_segWord[g]  = bus.seg_data[g*DATA_W +: DATA_W];
        assign w_segEmpty[g] = bus.seg_empty[g*EMPTY_W +: EMPTY_W];
    end

    assign w_isLast = (r_k == LAST_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_k     <= w_kNxt;
            r_tmo   <= w_tmoNxt;
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        w_kNxt     = r_k;
        w_tmoNxt   = r_tmo;
        w_pktInc   = 1'b0;
        w_abortInc = 1'b0;
        w_dropAdd  = '0;
        w_segReady = '0;
        w_outValid = 1'b0;
        w_outData  = '0;
        w_outSop   = 1'b0;
        w_outEop   = 1'b0;
        w_outEmpty = '0;

        case (r_state)
            // A stalled seg0 start-of-packet is held, not flushed, while disabled.
            ST_IDLE: begin
                w_kNxt   = '0;
                w_tmoNxt = '0;
                for (int k = 1; k < NUM_SEG; k++) begin
                    w_segReady[k] = 1'b1;
                    if (bus.seg_valid[k]) begin
                        w_dropAdd = w_dropAdd + DROP_ADD_W'(1);
                    end
                end
                if (bus.seg_valid[0] && !bus.seg_sop[0]) begin
                    w_segReady[0] = 1'b1;
                    w_dropAdd     = w_dropAdd + DROP_ADD_W'(1);
                end else if (bus.seg_valid[0] && w_enable) begin
                    w_outValid    = 1'b1;
                    w_outData     = w_segWord[0];
                    w_outSop      = 1'b1;
                    w_segReady[0] = bus.to_udp_ready;
                    if (bus.to_udp_ready) begin
                        w_stateNxt = ST_XFER;
                        w_kNxt     = bus.seg_eop[0] ? KW'(1) : '0;
                    end
                end
            end

            ST_XFER: begin
                w_outValid      = bus.seg_valid[r_k];
                w_outData       = w_segWord[r_k];
                w_segReady[r_k] = bus.to_udp_ready;
                if (w_isLast && bus.seg_eop[r_k]) begin
                    w_outEop   = 1'b1;
                    w_outEmpty = w_segEmpty[r_k];
                end
                if (bus.seg_valid[r_k] && bus.to_udp_ready) begin
                    w_tmoNxt = '0;
                    if (bus.seg_eop[r_k]) begin
                        if (w_isLast) begin
                            w_stateNxt = ST_IDLE;
                            w_kNxt     = '0;
                            w_pktInc   = 1'b1;
                        end else begin
                            w_kNxt = r_k + KW'(1);
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    w_tmoNxt = r_tmo + TMO_W'(1);
                    if (w_tmoNxt >= TMO_LIMIT) begin
                        w_stateNxt = ST_ABORT;
                        w_tmoNxt   = '0;
                    end
                end
            end

            ST_ABORT: begin
                w_outValid = 1'b1;
                w_outData  = ABORT_WORD;
                w_outEop   = 1'b1;
                if (bus.to_udp_ready) begin
                    w_stateNxt = ST_IDLE;
                    w_kNxt     = '0;
                    w_abortInc = 1'b1;
                end
            end

            default: begin
                w_stateNxt = ST_IDLE;
                w_kNxt     = '0;
                w_tmoNxt   = '0;
            end
        endcase

        // Outputs are forced quiet the instant reset asserts, not at the next edge.
        if (!rst_n) begin
            w_segReady = '0;
            w_outValid = 1'b0;
            w_outData  = '0;
            w_outSop   = 1'b0;
            w_outEop   = 1'b0;
            w_outEmpty = '0;
            w_dropAdd  = '0;
        end
    end

    assign bus.seg_ready    = w_segReady;
    assign bus.to_udp_valid = w_outValid;
    assign bus.to_udp_data  = w_outData;
    assign bus.to_udp_sop   = w_outSop;
    assign bus.to_udp_eop   = w_outEop;
    assign bus.to_udp_empty = w_outEmpty;

    st_seg_concat_csr u_csr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_address   (bus.csr_address),
        .i_read      (bus.csr_read),
        .i_write     (bus.csr_write),
        .i_writedata (bus.csr_writedata),
        .o_readdata  (bus.csr_readdata),
        .i_pktInc    (w_pktInc),
        .i_abortInc  (w_abortInc),
        .i_dropAdd   (w_dropAdd),
        .i_state     (r_state),
        .i_k         ({{(8 - KW){1'b0}}, r_k}),
        .o_enable    (w_enable)
    );

endmodule

// File: tb/tb_st_seg_concat.sv
// Scoreboard bench: segment drivers feed per-segment queues, expected merged
// beats are queued at issue time and a monitor compares every accepted beat.
module tb_st_seg_concat;

    localparam int NUM_SEG = 3;
    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    st_seg_concat_if #(.NUM_SEG(NUM_SEG), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) bus ();

    st_seg_concat #(
        .NUM_SEG    (NUM_SEG),
        .DATA_W     (DATA_W),
        .EMPTY_W    (EMPTY_W),
        .TIMEOUT    (TIMEOUT),
        .ABORT_WORD (32'hDEAD_BEEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t segQ [NUM_SEG][$];
    beat_t expQ [$];
    int    checks    = 0;
    int    errors    = 0;
    int    outCount  = 0;
    bit    readyMode = 1'b0;

    function automatic logic [31:0] wordOf(input int pkt, input int s, input int i);
        return {8'hA0 + 8'(s), 8'(pkt), 16'(i)};
    endfunction

    function automatic bit busy();
        return (expQ.size() != 0) || (segQ[0].size() != 0) ||
               (segQ[1].size() != 0) || (segQ[2].size() != 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Driver: present queue heads after the falling edge, retire them just before the rising edge.
    initial begin
        bit tog = 1'b1;
        bus.seg_data     = '0;
        bus.seg_valid    = '0;
        bus.seg_sop      = '0;
        bus.seg_eop      = '0;
        bus.seg_empty    = '0;
        bus.to_udp_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.to_udp_ready = readyMode ? tog : 1'b1;
            tog = ~tog;
            for (int k = 0; k < NUM_SEG; k++) begin
                if (segQ[k].size() != 0) begin
                    bus.seg_valid[k]               = 1'b1;
                    bus.seg_data[k*DATA_W +: DATA_W] = segQ[k][0].data;
                    bus.seg_sop[k]                 = segQ[k][0].sop;
                    bus.seg_eop[k]                 = segQ[k][0].eop;
                    bus.seg_empty[k*EMPTY_W +: EMPTY_W] = segQ[k][0].empty;
                end else begin
                    bus.seg_valid[k]               = 1'b0;
                    bus.seg_data[k*DATA_W +: DATA_W] = '0;
                    bus.seg_sop[k]                 = 1'b0;
                    bus.seg_eop[k]                 = 1'b0;
                    bus.seg_empty[k*EMPTY_W +: EMPTY_W] = '0;
                end
            end
            #4;
            for (int k = 0; k < NUM_SEG; k++) begin
                if (bus.seg_valid[k] && bus.seg_ready[k]) begin
                    void'(segQ[k].pop_front());
                end
            end
        end
    end

    // Monitor: every accepted merged beat must match the head of the scoreboard.
    initial begin
        beat_t got;
        beat_t exp;
        forever begin
            @(negedge clk);
            #4;
            if (bus.to_udp_valid && bus.to_udp_ready) begin
                got = {bus.to_udp_data, bus.to_udp_sop, bus.to_udp_eop, bus.to_udp_empty};
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat got=%h expected=none", got);
                end else begin
                    exp = expQ.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("[TB] FAIL beat%0d got=%h expected=%h", outCount, got, exp);
                    end
                end
                outCount++;
            end
        end
    end

    task automatic pushSegment(input int pkt, input int s, input int n, input bit noEop);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = wordOf(pkt, s, i);
            b.sop   = (i == 0);
            b.eop   = (i == n - 1) && !noEop;
            b.empty = b.eop ? ((s == NUM_SEG - 1) ? 2'd3 : 2'd2) : 2'd0;
            segQ[s].push_back(b);
        end
    endtask

    task automatic pushExpected(input int pkt, input int n0, input int n1, input int n2, input bit stall);
        beat_t b;
        for (int i = 0; i < n0; i++) begin
            b = {wordOf(pkt, 0, i), (i == 0), 1'b0, 2'd0};
            expQ.push_back(b);
        end
        for (int i = 0; i < n1; i++) begin
            b = {wordOf(pkt, 1, i), 1'b0, 1'b0, 2'd0};
            expQ.push_back(b);
        end
        if (stall) begin
            b = {32'hDEAD_BEEF, 1'b0, 1'b1, 2'd0};
            expQ.push_back(b);
        end else begin
            for (int i = 0; i < n2; i++) begin
                b = {wordOf(pkt, 2, i), 1'b0, (i == n2 - 1), (i == n2 - 1) ? 2'd3 : 2'd0};
                expQ.push_back(b);
            end
        end
    endtask

    task automatic waitHeadTaken(input int n0);
        int cnt = 0;
        while (segQ[0].size() >= n0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("head_taken", 32'(segQ[0].size() < n0), 32'd1);
    endtask

    // Later segments are only queued once the packet has started, else IDLE flushes them.
    task automatic startPacket(input int pkt, input int n0, input int n1, input int n2, input bit stall);
        pushExpected(pkt, n0, n1, n2, stall);
        pushSegment(pkt, 0, n0, 1'b0);
        waitHeadTaken(n0);
        pushSegment(pkt, 1, n1, stall);
        if (!stall) pushSegment(pkt, 2, n2, 1'b0);
    endtask

    task automatic waitDrained(input string name, input int budget);
        int cnt = 0;
        while (busy() && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        checkOutput(name, 32'(busy()), 32'd0);
    endtask

    task automatic waitOut(input string name, input int target);
        int cnt = 0;
        while (outCount < target && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput(name, 32'(outCount >= target), 32'd1);
    endtask

    task automatic csrWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.csr_address   = addr;
        bus.csr_writedata = data;
        bus.csr_write     = 1'b1;
        @(negedge clk);
        bus.csr_write     = 1'b0;
    endtask

    task automatic csrRead(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.csr_address = addr;
        bus.csr_read    = 1'b1;
        @(negedge clk);
        bus.csr_read    = 1'b0;
        data = bus.csr_readdata;
    endtask

    task automatic applyStimulus();
        logic [31:0] rd;
        int base;

        bus.csr_address   = '0;
        bus.csr_read      = 1'b0;
        bus.csr_write     = 1'b0;
        bus.csr_writedata = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus.to_udp_valid), 32'd0);
        checkOutput("rst_data", bus.to_udp_data, 32'd0);
        checkOutput("rst_seg_ready", 32'(bus.seg_ready), 32'd0);
        checkOutput("rst_readdata", bus.csr_readdata, 32'd0);
        rst_n = 1'b1;
        csrRead(2'd0, rd);
        checkOutput("rst_ctrl", rd, 32'd1);
        csrRead(2'd3, rd);
        checkOutput("rst_status", rd, 32'd0);

        // 3/160/4 segments with an always-ready sink
        base = outCount;
        startPacket(1, 3, 160, 4, 1'b0);
        waitDrained("pkt1_drain", 2000);
        checkOutput("pkt1_beats", 32'(outCount - base), 32'd167);
        csrRead(2'd1, rd);
        checkOutput("pkt1_count", rd, 32'd1);

        // Same packet with a 1010... sink ready pattern
        readyMode = 1'b1;
        base = outCount;
        startPacket(2, 3, 160, 4, 1'b0);
        waitDrained("pkt2_drain", 2000);
        checkOutput("pkt2_beats", 32'(outCount - base), 32'd167);
        csrRead(2'd1, rd);
        checkOutput("pkt2_count", rd, 32'd2);
        readyMode = 1'b0;

        // Segment 1 stalls after 5 words, forcing the timeout abort
        csrWrite(2'd0, 32'h3);
        startPacket(3, 3, 5, 0, 1'b1);
        waitDrained("abort_drain", 500);
        csrRead(2'd2, rd);
        checkOutput("abort_count", rd, 32'd1);
        csrRead(2'd1, rd);
        checkOutput("abort_pkt_count", rd, 32'd0);
        startPacket(6, 3, 4, 2, 1'b0);
        waitDrained("after_abort_drain", 500);
        csrRead(2'd1, rd);
        checkOutput("after_abort_pkt", rd, 32'd1);

        // Residue in IDLE: two seg2 beats plus one non-sop seg0 beat are flushed
        csrWrite(2'd0, 32'h3);
        pushSegment(20, 2, 2, 1'b0);
        segQ[0].push_back({wordOf(20, 0, 7), 1'b0, 1'b0, 2'd0});
        waitDrained("drop_drain", 100);
        csrRead(2'd3, rd);
        checkOutput("drop_status", rd, 32'h0003_0000);

        // Disable mid-packet: current packet completes, the next one is held
        csrWrite(2'd0, 32'h3);
        base = outCount;
        startPacket(4, 3, 20, 4, 1'b0);
        waitOut("en_progress", base + 8);
        csrWrite(2'd0, 32'h0);
        waitDrained("en_pkt4_drain", 500);
        csrRead(2'd1, rd);
        checkOutput("en_pkt4_count", rd, 32'd1);
        pushSegment(5, 0, 3, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("held_q0", 32'(segQ[0].size()), 32'd3);
        checkOutput("held_ready", 32'(bus.seg_ready[0]), 32'd0);
        checkOutput("held_valid", 32'(bus.to_udp_valid), 32'd0);
        pushExpected(5, 3, 4, 2, 1'b0);
        csrWrite(2'd0, 32'h1);
        waitHeadTaken(3);
        pushSegment(5, 1, 4, 1'b0);
        pushSegment(5, 2, 2, 1'b0);
        waitDrained("en_pkt5_drain", 500);
        csrRead(2'd1, rd);
        checkOutput("en_pkt5_count", rd, 32'd2);

        // Reset pulse at beat 80 abandons the packet; residue is flushed afterwards
        base = outCount;
        startPacket(7, 3, 160, 4, 1'b0);
        waitOut("rst_reach80", base + 80);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(bus.to_udp_valid), 32'd0);
        checkOutput("midrst_data", bus.to_udp_data, 32'd0);
        checkOutput("midrst_eop", 32'(bus.to_udp_eop), 32'd0);
        checkOutput("midrst_seg_ready", 32'(bus.seg_ready), 32'd0);
        expQ.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        waitDrained("residue_drain", 1000);
        csrRead(2'd1, rd);
        checkOutput("midrst_pkt_count", rd, 32'd0);
        csrRead(2'd2, rd);
        checkOutput("midrst_abort_count", rd, 32'd0);
        csrRead(2'd0, rd);
        checkOutput("midrst_ctrl", rd, 32'd1);
        base = outCount;
        startPacket(8, 3, 160, 4, 1'b0);
        waitDrained("clean_drain", 2000);
        checkOutput("clean_beats", 32'(outCount - base), 32'd167);
        csrRead(2'd1, rd);
        checkOutput("clean_pkt_count", rd, 32'd1);
        csrRead(2'd3, rd);
        checkOutput("final_state_k", {16'd0, rd[15:0]}, 32'd0);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/st_seg_concat.md
ST_SEG_CONCAT -- requirements
Module: st_seg_concat

Interface
REQ-001 Parameter NUM_SEG, default 3, number of input segment streams concatenated per packet (2..8).
REQ-002 Parameter DATA_W, default 32, Avalon-ST data width per stream.
REQ-003 Parameter EMPTY_W, default 2, empty field width.
REQ-004 Parameter TIMEOUT, default 1024, idle cycles inside a packet before abort; 0 disables the timeout.
REQ-005 Parameter ABORT_WORD, default 32'hDEAD_BEEF, data of the terminating beat after abort.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 seg_data  in  NUM_SEG*DATA_W  segment k at bits [k*DATA_W +: DATA_W].
REQ-009 seg_valid / seg_sop / seg_eop  in  NUM_SEG each  per-segment valid, startofpacket, endofpacket.
REQ-010 seg_empty  in  NUM_SEG*EMPTY_W  per-segment empty.
REQ-011 seg_ready  out  NUM_SEG  per-segment ready.
REQ-012 to_udp_data/valid/sop/eop/empty  out  DATA_W/1/1/1/EMPTY_W  merged source; to_udp_ready  in  1.
REQ-013 csr_address in 2, csr_read in 1, csr_write in 1, csr_writedata in 32, csr_readdata out 32: Avalon-MM slave, zero wait states, read data registered (1-cycle latency).

Function
REQ-014 States: IDLE, XFER(k), ABORT; k is the current segment index, 0..NUM_SEG-1.
REQ-015 Output forwarding is combinational, zero latency: in XFER(k), to_udp_data=seg_data[k], to_udp_valid=seg_valid[k], seg_ready[k]=to_udp_ready; all other seg_ready=0 except per REQ-020.
REQ-016 A beat transfers only when valid and ready are both 1 in the same cycle; state changes only on transferred beats, never on sop/eop level alone.
REQ-017 IDLE -> XFER(0) when enable=1 and seg_valid[0]=1 and seg_sop[0]=1; that beat is forwarded in the same cycle with to_udp_sop=1.
REQ-018 In XFER(k), k<NUM_SEG-1: a transferred beat with seg_eop[k]=1 moves to XFER(k+1); its sop/eop are stripped (to_udp_sop=to_udp_eop=0, to_udp_empty=0).
REQ-019 In XFER(NUM_SEG-1): a transferred beat with seg_eop=1 is forwarded with to_udp_eop=1 and to_udp_empty=seg_empty; state -> IDLE; packet counter +1.
REQ-020 Flush: in IDLE, seg_ready[k]=1 for k>=1 and seg_ready[0]=1 when seg_valid[0]=1 with seg_sop[0]=0; such beats are discarded and drop counter +1 per beat.
REQ-021 seg_sop on a non-first beat of a segment is ignored; data is forwarded.
REQ-022 Timeout counter clears on every transferred beat and on entry to XFER; increments each cycle in XFER(k) without a transfer; when it reaches TIMEOUT -> ABORT.
REQ-023 ABORT: to_udp_valid=1, data=ABORT_WORD, eop=1, empty=0, all seg_ready=0; on to_udp_ready=1 -> IDLE, abort counter +1.
REQ-024 enable=0 blocks only IDLE->XFER(0); a packet already in progress completes or aborts normally.
REQ-025 Outside XFER/ABORT: to_udp_valid=0, data=0, sop=eop=0, empty=0.
REQ-026 CSR map: 0 control (bit0 enable, reset 1; bit1 write-1 clears all counters, self-clearing); 1 packet count; 2 abort count; 3 {drop count[15:0], 5'b0, state[2:0], k[7:0]}.
REQ-027 Counters are 32 bit (drop 16 bit), saturate at all-ones; a clear coinciding with an increment yields 0.

Reset
REQ-028 On rst_n=0: state IDLE, k=0, timeout/packet/abort/drop counters 0, enable=1, csr_readdata=0, all seg_ready=0, to_udp outputs 0 per REQ-025.
REQ-029 Reset asserted mid-packet abandons it without emitting eop; after release, non-first-segment residue is flushed per REQ-020.

Structure
REQ-030 Shared package holds the state encoding, CSR address constants, and the counter widths.
REQ-031 One sub-module, st_seg_concat_csr, holds the control register, counters, and readback mux; the FSM and data mux stay in the top.

Verification
REQ-032 NUM_SEG=3, segments of 3/160/4 words, to_udp_ready=1 -> 167 contiguous beats, sop on beat 0 only, eop on beat 166 only; packet count=1.
REQ-033 Same stimulus, to_udp_ready toggling 1010... -> identical 167-word sequence, no duplicated or lost beats.
REQ-034 TIMEOUT=16, segment 1 stalls after 5 words -> after 16 idle cycles one beat 0xDEADBEEF with eop; abort count=1; next packet correct.
REQ-035 Segment 2 delivers 2 beats and seg0 sends 1 beat without sop while IDLE -> all 3 discarded; drop count=3; no to_udp_valid.
REQ-036 Clear enable during segment 1 -> current packet ends normally; next seg0 sop is held (seg_ready[0]=0) until enable=1 is written.
REQ-037 rst_n pulsed low at beat 80 -> all outputs 0 immediately; later clean packet output intact; counters 0 then 1.
